// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: round-robin arbiter with per-owner burst hold (clk, rst async active-low, req in; grant/grant_idx/grant_valid/burst_end out)
module mem_burst_arbiter #(
  parameter int PORT = 8,
  parameter int MAX_BURST = 16,
  parameter int IDXW = PORT > 1 ? $clog2(PORT) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PORT-1:0] req,
  output logic [PORT-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            burst_end
);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [BW-1:0] beat, beat_nxt;
  logic [IDXW-1:0] last_owner, last_nxt, idx_nxt, pick, k;
  logic hold, any;
  always_comb begin
    pick = '0;
    k = '0;
    for (int i = PORT; i >= 1; i--) begin
      k = IDXW'((int'(last_owner) + i) % PORT);
      if (req[k]) pick = k;
    end
  end
  assign any = |req;
  assign hold = state == GRANT && req[grant_idx] && beat != BEAT_MAX;
  assign burst_end = state == GRANT && req[grant_idx] && beat == BEAT_MAX;
  assign grant_valid = |grant;
  always_comb begin
    state_nxt = hold || any ? GRANT : IDLE;
    idx_nxt = hold ? grant_idx : any ? pick : '0;
    last_nxt = hold || !any ? last_owner : pick;
    beat_nxt = hold ? beat + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      grant_idx <= '0;
      beat <= '0;
      last_owner <= IDXW'(PORT - 1);
    end else begin
      state <= state_nxt;
      grant <= state_nxt == GRANT ? PORT'(1) << idx_nxt : '0;
      grant_idx <= idx_nxt;
      beat <= beat_nxt;
      last_owner <= last_nxt;
    end
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: randomized and directed checks of mem_burst_arbiter against a cycle-count reference model
module tb_mem_burst_arbiter;
  localparam int P = 4;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [P-1:0] req = '0;
  logic [P-1:0] grant;
  logic [1:0] grant_idx;
  logic grant_valid, burst_end;
  int n_chk = 0, n_pass = 0;
  int m_owner = -1, m_run = 0, m_last = P - 1;
  int waits[P];
  int max_wait = 0;
  always #5 clk = ~clk;
  mem_burst_arbiter #(.PORT(P), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .burst_end(burst_end)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [P-1:0] exp_grant();
    return m_owner >= 0 ? P'(1) << m_owner : '0;
  endfunction
  task automatic m_reset();
    m_owner = -1;
    m_run = 0;
    m_last = P - 1;
  endtask
  task automatic m_step(input logic [P-1:0] r);
    int p;
    if (m_owner >= 0 && r[m_owner] && m_run < MB) m_run++;
    else begin
      p = -1;
      for (int j = 1; j <= P; j++)
        if (p < 0 && r[(m_last + j) % P]) p = (m_last + j) % P;
      m_owner = p;
      m_run = p >= 0 ? 1 : 0;
      if (p >= 0) m_last = p;
    end
  endtask
  task automatic check_out();
    chk("grant", 32'(grant), 32'(exp_grant()));
    chk("idx", 32'(grant_idx), m_owner >= 0 ? 32'(m_owner) : 0);
    chk("valid", 32'(grant_valid), 32'(m_owner >= 0));
  endtask
  task automatic cycle(input logic [P-1:0] r);
    req = r;
    #1;
    chk("burst_end", 32'(burst_end), 32'(m_owner >= 0 && r[m_owner] && m_run == MB));
    @(posedge clk);
    m_step(r);
    @(negedge clk);
    check_out();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    m_reset();
    @(negedge clk);
    #1;
    check_out();
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    logic [P-1:0] r;
    @(negedge clk);
    #1;
    check_out();
    chk("burst_end_rst", 32'(burst_end), 0);
    @(negedge clk);
    rst = 1'b1;
    cycle(4'b0000);
    cycle(4'b0100);
    chk("t1_idx2", 32'(grant_idx), 2);
    do_reset();
    for (int i = 0; i < 20; i++) cycle(4'b1111);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(4'b0001);
    do_reset();
    cycle(4'b0010);
    cycle(4'b0010);
    cycle(4'b1000);
    chk("t4_handoff", 32'(grant), 32'h8);
    cycle(4'b0000);
    do_reset();
    cycle(4'b0100);
    cycle(4'b0100);
    #3;
    rst = 1'b0;
    m_reset();
    #1;
    chk("t5_async_grant", 32'(grant), 0);
    check_out();
    @(negedge clk);
    rst = 1'b1;
    cycle(4'b1111);
    chk("t5_port0_first", 32'(grant), 32'h1);
    for (int i = 0; i < P; i++) waits[i] = 0;
    r = '0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < P; i++)
        if (!(r[i] && !grant[i])) r[i] = ($urandom_range(0, 2) == 0);
      cycle(r);
      for (int i = 0; i < P; i++) begin
        waits[i] = (r[i] && !grant[i]) ? waits[i] + 1 : 0;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
    end
    chk("max_wait_le_13", 32'(max_wait <= 3 * MB + 1), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
